// File: rtl/simple_cnn.sv
// 28x28 8-bit image store with a 3x3 edge kernel (centre +8, neighbours -1) streaming the 26x26 map.
// Optional build macro CONV_RELU_EN clamps negative results to zero before the output register.
module simple_cnn #(
    parameter int IMG_DIM = 28,
    parameter int PIX_W   = 8,
    parameter int OUT_W   = 13
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             pix_we,
    input  logic [9:0]                       pix_addr,
    input  logic [PIX_W-1:0]                 pix_wdata,
    output logic [IMG_DIM*IMG_DIM*PIX_W-1:0] image_array,
    output logic                             busy,
    output logic                             done,
    output logic                             feat_valid,
    output logic [4:0]                       feat_row,
    output logic [4:0]                       feat_col,
    output logic signed [OUT_W-1:0]          feat_data
);

    localparam int         NPIX   = IMG_DIM * IMG_DIM;
    localparam logic [9:0] NPIX_A = 10'(NPIX);
    localparam logic [4:0] LAST   = 5'(IMG_DIM - 3);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state_q;
    logic                    busy_q, done_q, vld_q, last_q;
    logic [4:0]              row_q, col_q, cur_r_q, cur_c_q;
    logic signed [OUT_W-1:0] data_q;
    logic [PIX_W-1:0]        pix_q [NPIX];

    logic [9:0]              base;
    logic [PIX_W+2:0]        nsum;
    logic [PIX_W-1:0]        centre;
    logic signed [OUT_W-1:0] conv_d;

    function automatic logic signed [OUT_W-1:0] out_stage(input logic signed [OUT_W-1:0] x);
`ifdef CONV_RELU_EN
        return (x < 0) ? '0 : x;
`else
        return x;
`endif
    endfunction

    // Window whose top-left corner is (cur_r_q, cur_c_q); centre sits one row and one column in.
    always_comb begin
        base   = 10'(cur_r_q) * 10'(IMG_DIM) + 10'(cur_c_q);
        nsum   = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (!(i == 1 && j == 1))
                    nsum = nsum + (PIX_W+3)'(pix_q[base + 10'(i*IMG_DIM + j)]);
            end
        end
        centre = pix_q[base + 10'(IMG_DIM + 1)];
        conv_d = $signed({2'b00, centre, 3'b000}) - $signed({2'b00, nsum});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            cur_r_q <= '0;
            cur_c_q <= '0;
            data_q  <= '0;
            for (int k = 0; k < NPIX; k++)
                pix_q[k] <= PIX_W'(k);
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE && pix_we && pix_addr < NPIX_A)
                pix_q[pix_addr] <= pix_wdata;
            case (state_q)
                IDLE: begin
                    vld_q <= 1'b0;
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        last_q  <= 1'b0;
                        cur_r_q <= '0;
                        cur_c_q <= '0;
                    end
                end
                RUN: begin
                    if (last_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        vld_q   <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        vld_q  <= 1'b1;
                        row_q  <= cur_r_q;
                        col_q  <= cur_c_q;
                        data_q <= out_stage(conv_d);
                        if (cur_c_q == LAST) begin
                            cur_c_q <= '0;
                            if (cur_r_q == LAST)
                                last_q <= 1'b1;
                            else
                                cur_r_q <= cur_r_q + 5'd1;
                        end else begin
                            cur_c_q <= cur_c_q + 5'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < NPIX; k++) begin : g_img
        assign image_array[k*PIX_W +: PIX_W] = pix_q[k];
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign feat_valid = vld_q;
    assign feat_row   = row_q;
    assign feat_col   = col_q;
    assign feat_data  = data_q;

endmodule

// File: tb/tb_simple_cnn.sv
// Scoreboard bench for simple_cnn: expected results are queued at start, a negedge monitor pops and compares.
module tb_simple_cnn;

    logic         clk = 1'b0;
    logic         rst, start, pix_we;
    logic [9:0]   pix_addr;
    logic [7:0]   pix_wdata;
    logic [6271:0] image_array;
    logic         busy, done, feat_valid;
    logic [4:0]   feat_row, feat_col;
    logic signed [12:0] feat_data;

    simple_cnn dut (
        .clk(clk), .rst(rst), .start(start), .pix_we(pix_we), .pix_addr(pix_addr),
        .pix_wdata(pix_wdata), .image_array(image_array), .busy(busy), .done(done),
        .feat_valid(feat_valid), .feat_row(feat_row), .feat_col(feat_col), .feat_data(feat_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [22:0] exp_q [$];
    logic [7:0]  img [784];
    int r00 = 99999, r82 = 99999, r83 = 99999;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int conv_model(input int r, input int c);
        int s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                if (i == 1 && j == 1) s += 8 * int'(img[(r+i)*28 + c + j]);
                else                  s -= int'(img[(r+i)*28 + c + j]);
`ifdef CONV_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    task automatic push_exp();
        for (int r = 0; r < 26; r++)
            for (int c = 0; c < 26; c++)
                exp_q.push_back({5'(r), 5'(c), 13'(conv_model(r, c))});
    endtask

    task automatic reset_model();
        for (int k = 0; k < 784; k++) img[k] = 8'(k);
    endtask

    task automatic cmp_image(input string name);
        int bad = 0;
        for (int k = 0; k < 784; k++)
            if (image_array[k*8 +: 8] !== img[k]) bad++;
        check(name, bad, 0);
    endtask

    // Monitor: every valid result must match the head of the scoreboard.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (feat_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                logic [22:0] e;
                e = exp_q.pop_front();
                check("feat", int'({feat_row, feat_col, feat_data}), int'(e));
            end
            if (feat_row == 5'd0 && feat_col == 5'd0) r00 = int'(feat_data);
            if (feat_row == 5'd8 && feat_col == 5'd2) r82 = int'(feat_data);
            if (feat_row == 5'd8 && feat_col == 5'd3) r83 = int'(feat_data);
        end
    end

    // Caller sets start (and any same-edge write) and has pushed expectations.
    task automatic do_run(input bit disturb, input bit chain);
        tick();
        start = 0; pix_we = 0;
        check("busy_at_start", int'(busy), 1);
        check("valid_at_start", int'(feat_valid), 0);
        for (int k = 1; k <= 676; k++) begin
            tick();
            check("valid_in_run", int'(feat_valid), 1);
            check("busy_in_run", int'(busy), 1);
            check("done_in_run", int'(done), 0);
            if (disturb && k == 10) begin
                start = 1; pix_we = 1; pix_addr = 10'd29; pix_wdata = 8'h00;
            end
            if (k == 14) begin
                start = 0; pix_we = 0;
            end
        end
        tick();
        check("valid_after_run", int'(feat_valid), 0);
        check("busy_after_run", int'(busy), 0);
        check("done_pulse", int'(done), 1);
        check("scoreboard_drained", exp_q.size(), 0);
        if (chain) begin
            push_exp();
            start = 1;
        end else begin
            tick();
            check("done_cleared", int'(done), 0);
        end
    endtask

    initial begin
        rst = 1; start = 0; pix_we = 0; pix_addr = '0; pix_wdata = '0;
        reset_model();
        tick(); tick();
        rst = 0;
        check("rst_pix0", int'(image_array[7:0]), 8'h00);
        check("rst_pix29", int'(image_array[29*8 +: 8]), 8'h1D);
        check("rst_pix255", int'(image_array[255*8 +: 8]), 8'hFF);
        check("rst_pix256", int'(image_array[256*8 +: 8]), 8'h00);
        check("rst_pix783", int'(image_array[783*8 +: 8]), 8'h0F);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_valid", int'(feat_valid), 0);
        check("rst_data", int'(feat_data), 0);
        cmp_image("rst_image");

        // Run on the reset pattern, with start and a write attempted mid-run.
        push_exp();
        start = 1;
        do_run(1, 0);
        check("r00_pattern", r00, 0);
        check("r82_pattern", r82, 1024);
`ifdef CONV_RELU_EN
        check("r83_pattern", r83, 0);
`else
        check("r83_pattern", r83, -1024);
`endif
        check("one_done_run1", done_cnt, 1);
        cmp_image("image_after_busy_write");

        // Write committed on the start edge, then a back-to-back second run.
        img[29] = 8'hFF;
        pix_we = 1; pix_addr = 10'd29; pix_wdata = 8'hFF;
        push_exp();
        start = 1;
        do_run(0, 1);
        check("r00_written", r00, 1808);
        check("img_bits_239_232", int'(image_array[239:232]), 8'hFF);
        r00 = 99999;
        do_run(0, 0);
        check("r00_b2b", r00, 1808);
        check("done_cnt_b2b", done_cnt, 3);

        // Out-of-range write is dropped.
        pix_we = 1; pix_addr = 10'd800; pix_wdata = 8'hAA;
        tick();
        pix_we = 0;
        cmp_image("oob_write");

        // Reset at result 100 aborts the run.
        push_exp();
        start = 1;
        tick();
        start = 0;
        for (int k = 0; k < 100; k++) tick();
        check("valid_before_abort", int'(feat_valid), 1);
        rst = 1;
        tick();
        rst = 0;
        check("abort_busy", int'(busy), 0);
        check("abort_valid", int'(feat_valid), 0);
        check("abort_done", int'(done), 0);
        reset_model();
        cmp_image("abort_image_reload");
        exp_q.delete();
        for (int k = 0; k < 700; k++) tick();
        check("abort_no_done", done_cnt, 3);
        check("abort_idle_valid", int'(feat_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
